// File: rtl/packet_types_pkg.sv
// rtl/packet_types_pkg.sv - serializer FSM states and packet length limits.
package packet_types;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  localparam int MIN_NUM_OF_FLIT = 2;

endpackage

// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - flit, flit id and flit type definitions shared across the NoC.
package types;

  typedef logic [3:0] flit_num_t;
  typedef logic [2:0] packet_id_t;

  typedef enum logic [1:0] {
    BODY = 2'b00,
    HEAD = 2'b01,
    TAIL = 2'b10
  } flit_type_t;

  typedef struct packed {
    packet_id_t packet_id;
    flit_num_t  flit_num;
  } flit_id_t;

  typedef struct packed {
    flit_type_t  flittype;
    flit_id_t    flit_id;
    logic [15:0] payload;
  } flit_t;

endpackage

// File: rtl/flit_header_gen.sv
// rtl/flit_header_gen.sv - stamps flittype, flit_num and packet_id onto a payload flit.
module flit_header_gen
  import types::*;
(
  input  flit_t      i_flit,
  input  flit_num_t  i_k,
  input  flit_num_t  i_num,
  input  packet_id_t i_id,
  output flit_t      o_flit
);

  always_comb begin
    o_flit = i_flit;
    if (i_k == '0) begin
      o_flit.flittype = HEAD;
    end else if (i_k == i_num - flit_num_t'(1)) begin
      o_flit.flittype = TAIL;
    end else begin
      o_flit.flittype = BODY;
    end
    o_flit.flit_id.flit_num  = i_k;
    o_flit.flit_id.packet_id = i_id;
  end

endmodule

// File: rtl/packet_serializer.sv
// rtl/packet_serializer.sv - captures a whole packet and emits it one stamped flit per handshake.
module packet_serializer #(
  parameter int MAX_NUM_OF_FLIT = 8,
  parameter int MIN_NUM_OF_FLIT = packet_types::MIN_NUM_OF_FLIT
) (
  input  logic                                 nocclk,
  input  logic                                 rst_n,
  input  types::flit_t [MAX_NUM_OF_FLIT-1:0]   tx_flits,
  input  types::flit_num_t                     tx_num_flit,
  input  logic                                 tx_packet_valid,
  output logic                                 tx_packet_ready,
  output types::flit_t                         next_flit,
  output logic                                 next_flit_valid,
  input  logic                                 next_flit_ready,
  output types::packet_id_t                    sent_packet_id,
  output logic                                 tx_packet_done,
  output logic                                 tx_packet_error
);

  import types::*;
  import packet_types::*;

  localparam int IDX_W = (MAX_NUM_OF_FLIT > 1) ? $clog2(MAX_NUM_OF_FLIT) : 1;
  localparam flit_num_t MinNum = flit_num_t'(MIN_NUM_OF_FLIT);
  localparam flit_num_t MaxNum = flit_num_t'(MAX_NUM_OF_FLIT);

  ser_state_t                        r_state;
  ser_state_t                        w_state_nxt;
  flit_t [MAX_NUM_OF_FLIT-1:0]       r_flits;
  flit_num_t                         r_num;
  flit_num_t                         r_k;
  packet_id_t                        r_id;
  packet_id_t                        r_id_cnt;
  logic                              r_done;
  logic                              r_error;

  logic                              w_legal;
  logic                              w_accept;
  logic                              w_hs;
  logic                              w_last;
  logic [IDX_W-1:0]                  w_idx;
  flit_t                             w_stamped;

  assign w_legal  = (tx_num_flit >= MinNum) && (tx_num_flit <= MaxNum);
  assign w_accept = tx_packet_valid && (r_state == IDLE);
  assign w_hs     = next_flit_ready && (r_state == SEND);
  assign w_last   = (r_k == r_num - flit_num_t'(1));
  assign w_idx    = r_k[IDX_W-1:0];

  flit_header_gen u_header_gen (
    .i_flit (r_flits[w_idx]),
    .i_k    (r_k),
    .i_num  (r_num),
    .i_id   (r_id),
    .o_flit (w_stamped)
  );

  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    tx_packet_ready = 1'b0;
    next_flit_valid = 1'b0;
    next_flit       = '0;
    case (r_state)
      IDLE: begin
        tx_packet_ready = 1'b1;
        if (tx_packet_valid && w_legal) begin
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        next_flit_valid = 1'b1;
        next_flit       = w_stamped;
        if (next_flit_ready && w_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Illegal lengths are consumed in IDLE but never touch the capture or id state.
  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      r_flits  <= '0;
      r_num    <= '0;
      r_k      <= '0;
      r_id     <= '0;
      r_id_cnt <= '0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_done  <= w_hs && w_last;
      r_error <= w_accept && !w_legal;
      if (w_accept && w_legal) begin
        r_flits  <= tx_flits;
        r_num    <= tx_num_flit;
        r_k      <= '0;
        r_id     <= r_id_cnt;
        r_id_cnt <= r_id_cnt + packet_id_t'(1);
      end else if (w_hs && !w_last) begin
        r_k <= r_k + flit_num_t'(1);
      end
    end
  end

  assign sent_packet_id  = r_id;
  assign tx_packet_done  = r_done;
  assign tx_packet_error = r_error;

endmodule

// File: tb/tb_packet_serializer.sv
// tb/tb_packet_serializer.sv - directed table-driven bench for packet_serializer.
module tb_packet_serializer;

  import types::*;

  localparam int MAX = 8;

  logic                    nocclk = 1'b0;
  logic                    rst_n;
  flit_t [MAX-1:0]         tx_flits;
  flit_num_t               tx_num_flit;
  logic                    tx_packet_valid;
  logic                    tx_packet_ready;
  flit_t                   next_flit;
  logic                    next_flit_valid;
  logic                    next_flit_ready;
  packet_id_t              sent_packet_id;
  logic                    tx_packet_done;
  logic                    tx_packet_error;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    flit_num_t   num;
    logic [15:0] base;
    logic        err;
    packet_id_t  id;
  } vec_t;

  vec_t vecs [8];
  int   pat_rdy [5] = '{0, 0, 1, 0, 1};
  int   pat_k   [5] = '{0, 0, 0, 1, 1};

  always #5 nocclk = ~nocclk;

  packet_serializer #(.MAX_NUM_OF_FLIT(MAX), .MIN_NUM_OF_FLIT(2)) dut (
    .nocclk          (nocclk),
    .rst_n           (rst_n),
    .tx_flits        (tx_flits),
    .tx_num_flit     (tx_num_flit),
    .tx_packet_valid (tx_packet_valid),
    .tx_packet_ready (tx_packet_ready),
    .next_flit       (next_flit),
    .next_flit_valid (next_flit_valid),
    .next_flit_ready (next_flit_ready),
    .sent_packet_id  (sent_packet_id),
    .tx_packet_done  (tx_packet_done),
    .tx_packet_error (tx_packet_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Header fields are loaded with junk so the bench sees them being overwritten.
  task automatic load(input flit_num_t num, input logic [15:0] base);
    for (int i = 0; i < MAX; i++) begin
      tx_flits[i].flittype = TAIL;
      tx_flits[i].flit_id  = '1;
      tx_flits[i].payload  = base + 16'(i);
    end
    tx_num_flit = num;
  endtask

  function automatic flit_t exp_flit(input flit_num_t k, input flit_num_t num,
                                     input packet_id_t id, input logic [15:0] base);
    flit_t f;
    f.flittype          = (k == 0) ? HEAD : ((k == num - 1) ? TAIL : BODY);
    f.flit_id.packet_id = id;
    f.flit_id.flit_num  = k;
    f.payload           = base + 16'(k);
    return f;
  endfunction

  task automatic send_packet(input flit_num_t num, input logic [15:0] base,
                             input logic exp_err, input packet_id_t exp_id);
    check("accept_ready", 32'(tx_packet_ready), 32'd1);
    load(num, base);
    tx_packet_valid = 1'b1;
    next_flit_ready = 1'b1;
    @(negedge nocclk);
    tx_packet_valid = 1'b0;
    if (exp_err) begin
      check("err_pulse", 32'(tx_packet_error), 32'd1);
      check("err_no_valid", 32'(next_flit_valid), 32'd0);
      check("err_ready", 32'(tx_packet_ready), 32'd1);
      @(negedge nocclk);
      check("err_clear", 32'(tx_packet_error), 32'd0);
      check("err_no_valid2", 32'(next_flit_valid), 32'd0);
    end else begin
      for (int k = 0; k < int'(num); k++) begin
        check("flit_valid", 32'(next_flit_valid), 32'd1);
        check("busy_not_ready", 32'(tx_packet_ready), 32'd0);
        check("flit", 32'(next_flit), 32'(exp_flit(flit_num_t'(k), num, exp_id, base)));
        check("sent_id", 32'(sent_packet_id), 32'(exp_id));
        load(flit_num_t'(MAX + 1), ~base);
        @(negedge nocclk);
      end
      check("done_pulse", 32'(tx_packet_done), 32'd1);
      check("ready_back", 32'(tx_packet_ready), 32'd1);
      check("valid_drop", 32'(next_flit_valid), 32'd0);
      @(negedge nocclk);
      check("done_clear", 32'(tx_packet_done), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int hs;
    vecs[0] = '{num: 4'd1,  base: 16'h0100, err: 1'b1, id: 3'd0};
    vecs[1] = '{num: 4'd9,  base: 16'h0200, err: 1'b1, id: 3'd0};
    vecs[2] = '{num: 4'd4,  base: 16'h1000, err: 1'b0, id: 3'd0};
    vecs[3] = '{num: 4'd2,  base: 16'h2000, err: 1'b0, id: 3'd1};
    vecs[4] = '{num: 4'd0,  base: 16'h0300, err: 1'b1, id: 3'd0};
    vecs[5] = '{num: 4'd8,  base: 16'h3000, err: 1'b0, id: 3'd2};
    vecs[6] = '{num: 4'd15, base: 16'h0400, err: 1'b1, id: 3'd0};
    vecs[7] = '{num: 4'd3,  base: 16'h4000, err: 1'b0, id: 3'd3};

    rst_n           = 1'b0;
    tx_packet_valid = 1'b0;
    next_flit_ready = 1'b0;
    load(4'd0, 16'h0);
    @(negedge nocclk);
    check("rst_valid", 32'(next_flit_valid), 32'd0);
    check("rst_flit", 32'(next_flit), 32'd0);
    check("rst_sent_id", 32'(sent_packet_id), 32'd0);
    check("rst_done", 32'(tx_packet_done), 32'd0);
    check("rst_error", 32'(tx_packet_error), 32'd0);
    rst_n = 1'b1;
    @(negedge nocclk);
    check("ready_after_rst", 32'(tx_packet_ready), 32'd1);

    for (int v = 0; v < 8; v++) begin
      send_packet(vecs[v].num, vecs[v].base, vecs[v].err, vecs[v].id);
    end

    // Backpressure on a 2-flit packet while tx_flits churns underneath.
    load(4'd2, 16'h5500);
    tx_packet_valid = 1'b1;
    next_flit_ready = 1'b0;
    @(negedge nocclk);
    tx_packet_valid = 1'b0;
    hs = 0;
    for (int i = 0; i < 5; i++) begin
      next_flit_ready = pat_rdy[i][0];
      check("bp_valid", 32'(next_flit_valid), 32'd1);
      check("bp_flit", 32'(next_flit), 32'(exp_flit(flit_num_t'(pat_k[i]), 4'd2, 3'd4, 16'h5500)));
      if (next_flit_valid && next_flit_ready) hs++;
      load(4'd7, 16'hBEE0 + 16'(i));
      @(negedge nocclk);
    end
    next_flit_ready = 1'b1;
    check("bp_handshakes", 32'(hs), 32'd2);
    check("bp_done", 32'(tx_packet_done), 32'd1);
    check("bp_valid_drop", 32'(next_flit_valid), 32'd0);
    @(negedge nocclk);
    check("bp_done_clear", 32'(tx_packet_done), 32'd0);

    // Reset lands mid-packet, after the BODY(1) handshake of an 8-flit packet.
    load(4'd8, 16'h6600);
    tx_packet_valid = 1'b1;
    @(negedge nocclk);
    tx_packet_valid = 1'b0;
    check("mid_head", 32'(next_flit), 32'(exp_flit(4'd0, 4'd8, 3'd5, 16'h6600)));
    @(negedge nocclk);
    check("mid_body1", 32'(next_flit), 32'(exp_flit(4'd1, 4'd8, 3'd5, 16'h6600)));
    @(negedge nocclk);
    check("mid_body2", 32'(next_flit), 32'(exp_flit(4'd2, 4'd8, 3'd5, 16'h6600)));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(next_flit_valid), 32'd0);
    check("async_flit", 32'(next_flit), 32'd0);
    check("async_sent_id", 32'(sent_packet_id), 32'd0);
    @(negedge nocclk);
    rst_n = 1'b1;
    @(negedge nocclk);
    check("post_rst_ready", 32'(tx_packet_ready), 32'd1);
    check("post_rst_done", 32'(tx_packet_done), 32'd0);

    // Nine legal packets from a fresh counter: ids 0..7 then wrap to 0.
    for (int p = 0; p < 9; p++) begin
      send_packet(flit_num_t'(2 + (p % 3)), 16'h7000 + 16'(p * 16), 1'b0, packet_id_t'(p % 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/packet_serializer.md
PACKET_SERIALIZER -- requirements
Module: packet_serializer

Interface
REQ-001 The module SHALL have parameter MAX_NUM_OF_FLIT, default 8, giving the maximum number of flits per packet.
REQ-002 The module SHALL have parameter MIN_NUM_OF_FLIT, default 2, giving the minimum legal flits per packet (HEAD plus TAIL).
REQ-003 Port nocclk  input  1  single clock; all state on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port tx_flits  input  MAX_NUM_OF_FLIT x types::flit_t  payload flits; header fields are ignored and overwritten.
REQ-006 Port tx_num_flit  input  flit_num_t  number of valid entries in tx_flits.
REQ-007 Port tx_packet_valid  input  1  tx_flits/tx_num_flit hold a packet.
REQ-008 Port tx_packet_ready  output  1  serializer can accept a packet.
REQ-009 Port next_flit  output  types::flit_t  outgoing flit with header filled in.
REQ-010 Port next_flit_valid  output  1  next_flit is valid.
REQ-011 Port next_flit_ready  input  1  downstream accepts next_flit.
REQ-012 Port sent_packet_id  output  packet_id_t  packet_id of the packet currently or last sent.
REQ-013 Port tx_packet_done  output  1  one-cycle pulse after the TAIL handshake.
REQ-014 Port tx_packet_error  output  1  one-cycle pulse when an illegal-length packet is dropped.

Function
REQ-015 The FSM SHALL have states IDLE and SEND.
- tx_packet_ready = (state==IDLE).
- next_flit_valid = (state==SEND).
REQ-016 In IDLE, when tx_packet_valid and tx_packet_ready are both high with MIN_NUM_OF_FLIT <= tx_num_flit <= MAX_NUM_OF_FLIT, the block SHALL:
- capture tx_flits and tx_num_flit into local registers;
- assign packet_id = id_counter;
- increment id_counter modulo 2^width(packet_id_t);
- clear the flit index k to 0;
- enter SEND.
REQ-017 An illegal tx_num_flit (below MIN or above MAX) SHALL be handled as follows:
- the packet is accepted and dropped;
- tx_packet_error pulses for one cycle;
- id_counter is unchanged;
- the state stays IDLE.
REQ-018 In SEND, next_flit SHALL equal captured flit[k], with header fields overridden as follows:
- flittype = HEAD if k==0, TAIL if k==num-1, BODY otherwise;
- flit_id.flit_num = k;
- flit_id.packet_id = the captured id.
REQ-019 While next_flit_valid is high and next_flit_ready is low, next_flit SHALL remain bit-stable; valid SHALL never drop before the handshake.
REQ-020 On a handshake (next_flit_valid & next_flit_ready) with k < num-1, k SHALL increment by 1.
REQ-021 On the handshake of the TAIL flit, the block SHALL return to IDLE in the next cycle and tx_packet_done SHALL pulse high for exactly that cycle.
REQ-022 Latency and throughput:
- the first flit is valid on the cycle after packet acceptance;
- an N-flit packet with ready held high occupies exactly N+1 cycles from accept to the next tx_packet_ready;
- there is no back-to-back acceptance.
REQ-023 sent_packet_id SHALL update on acceptance and hold until the next acceptance.
REQ-024 Changes on tx_flits/tx_num_flit during SEND SHALL have no effect on output.
REQ-025 id_counter SHALL wrap from its maximum value to 0 without a skip or an error.

Reset
REQ-026 On rst_n low, regardless of state (including mid-packet), the block SHALL asynchronously:
- enter IDLE;
- set k=0 and id_counter=0;
- drive next_flit_valid=0, tx_packet_done=0, tx_packet_error=0, sent_packet_id=0, next_flit='0;
- abandon any partially sent packet with no TAIL.
REQ-027 tx_packet_ready SHALL be 1 in the first cycle after reset deassertion.

Structure
REQ-028 packet_types SHALL hold:
- the serializer FSM state enum;
- MIN_NUM_OF_FLIT as a package constant.
types SHALL keep flit_t, flit_num_t, packet_id_t and the HEAD/BODY/TAIL encodings.
REQ-029 Header stamping (flittype/flit_num/packet_id from k, num, id) SHALL be a combinational sub-module flit_header_gen; all other logic is flat in packet_serializer.

Verification
REQ-030 4-flit packet, next_flit_ready=1 -> HEAD(0), BODY(1), BODY(2), TAIL(3) on consecutive cycles, all with packet_id 0; done pulses once; ready returns after 5 cycles.
REQ-031 2-flit packet, next_flit_ready toggled 0,0,1,0,1 -> HEAD held stable for 3 cycles, then TAIL held 2 cycles; exactly 2 handshakes occur; done pulses once.
REQ-032 tx_num_flit=1, then 9 (MAX=8) -> two error pulses, no flits emitted; the next legal packet carries packet_id 0.
REQ-033 2^width(packet_id_t)+1 legal packets sent -> ids run 0..max, then 0; each packet has a strictly increasing flit_num.
REQ-034 rst_n asserted after the BODY(1) handshake of an 8-flit packet -> valid drops asynchronously; after release, ready=1, and the next packet is HEAD with id 0.
REQ-035 tx_flits changed every cycle during SEND -> emitted payloads match the values captured at acceptance.
